// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller:
// opcode values, ALUOp / ALUSrcB / PCSource encodings, the 4-bit state
// enum and the packed control-word struct used inside the controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_mips_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode and memory handshake into the
// controller, mux selects and write enables out of it.
//   master : the controller (drives strobes, reads opcode/mem_ready)
//   slave  : the datapath / memory side
interface mc_mips_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// Memory-wait timer: counts consecutive not-ready cycles spent in a memory
// state and flags a timeout once MEM_WAIT_MAX such cycles have elapsed and
// memory is still not ready.
//   clk, rst : clock, synchronous active-low reset
//   active   : controller is in a memory-access state
//   ready    : memory completes the access this cycle
//   timeout  : abort the access this cycle
module mc_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  localparam int W = $clog2(MEM_WAIT_MAX + 1);

  logic [W-1:0] cnt;

  // ready in the limit cycle still counts as a normal completion
  assign timeout = active && !ready && (cnt == W'(MEM_WAIT_MAX));

  // every memory state exits on ready or timeout, so clearing whenever we
  // are not stalling doubles as the clear on state entry
  always_ff @(posedge clk) begin
    if (!rst)                             cnt <= '0;
    else if (active && !ready && !timeout) cnt <= cnt + W'(1);
    else                                  cnt <= '0;
  end
endmodule

// File: rtl/mc_mips_ctrl.sv
// Multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and enables over the bus interface,
// stalls on mem_ready, counts retired instructions and pulses illegal_op /
// mem_err.
// Optional feature: define MC_MIPS_CTRL_ADDI_EN to build ADDIEX/ADDIWB for
// addi; otherwise opcode 001000 decodes as illegal.
//   clk, rst   : clock, synchronous active-low reset
//   bus        : mc_mips_ctrl_if.master (opcode, mem_ready, control strobes)
//   state      : current state encoding (debug)
//   instr_done : pulse in the retiring cycle
//   illegal_op : pulse on unsupported opcode in DECODE
//   mem_err    : pulse on memory-wait timeout
//   retired    : retired-instruction count (wraps)
module mc_mips_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  mc_mips_ctrl_if.master    bus,
  output logic [3:0]        state,
  output logic              instr_done,
  output logic              illegal_op,
  output logic              mem_err,
  output logic [CNT_W-1:0]  retired
);
  state_t cur, nxt;
  ctrl_t  ctl;
  logic   mem_st, timeout, retire, illegal;

  assign mem_st = cur inside {S_FETCH, S_MEMRD, S_MEMWR};

  mc_mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .active  (mem_st),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  // Outputs are decoded from the registered state; FETCH/MEMWR completion
  // depends on mem_ready in the same cycle, so this is Mealy by nature.
  always_comb begin
    ctl     = '0;
    nxt     = cur;
    retire  = 1'b0;
    illegal = 1'b0;
    case (cur)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          nxt          = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
`ifdef MC_MIPS_CTRL_ADDI_EN
          OP_ADDI:      nxt = S_ADDIEX;
`endif
          default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        nxt           = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (bus.mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        retire         = 1'b1;
        nxt            = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_FUNCT;
        nxt           = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        retire        = 1'b1;
        nxt           = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REG;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
        retire            = 1'b1;
        nxt               = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
        retire        = 1'b1;
        nxt           = S_FETCH;
      end
`ifdef MC_MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        nxt           = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
        retire        = 1'b1;
        nxt           = S_FETCH;
      end
`endif
      default: nxt = S_FETCH;
    endcase

    // timeout aborts the access: nothing is written, PC keeps its value
    if (timeout) begin
      ctl    = '0;
      retire = 1'b0;
      nxt    = S_FETCH;
    end

    if (!rst) begin
      ctl     = '0;
      retire  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur     <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign state      = cur;
  assign instr_done = retire;
  assign illegal_op = illegal;
  assign mem_err    = timeout && rst;

  assign bus.PCWrite     = ctl.pc_write;
  assign bus.PCWriteCond = ctl.pc_write_cond;
  assign bus.IorD        = ctl.i_or_d;
  assign bus.MemRead     = ctl.mem_read;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.IRWrite     = ctl.ir_write;
  assign bus.MemtoReg    = ctl.mem_to_reg;
  assign bus.RegDst      = ctl.reg_dst;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.ALUSrcA     = ctl.alu_src_a;
  assign bus.ALUSrcB     = ctl.alu_src_b;
  assign bus.ALUOp       = ctl.alu_op;
  assign bus.PCSource    = ctl.pc_source;
endmodule

// File: tb/tb_mc_mips_ctrl.sv
// Bench for mc_mips_ctrl: directed instruction sequences with literal
// expectations, plus a route-queue reference model compared every cycle.
module tb_mc_mips_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_mips_ctrl_if bus();
  logic [3:0]  state;
  logic        instr_done, illegal_op, mem_err;
  logic [31:0] retired;

  mc_mips_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_err    (mem_err),
    .retired    (retired)
  );

  logic [15:0] dut_ctl;
  assign dut_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                    bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.PCSource};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Control word each state must present, straight from the state table.
  function automatic logic [15:0] spec_ctl(input int s, input bit rdy);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic m2r = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (s)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  // Reference model: after DECODE, an instruction is the queue of states it
  // still has to visit; it retires when the last one completes.
  int m_state = 0, m_wait = 0, m_ret = 0, nxt;
  int path[$];
  int rq[$];
  bit m_valid = 0;
  bit is_mem, fin, e_err, e_ill, e_done;
  logic [15:0] e_ctl;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        chk("rst_state", int'(state), m_state);
        chk("rst_ctl", int'(dut_ctl), 0);
        chk("rst_flags", int'({instr_done, illegal_op, mem_err}), 0);
      end
      m_state = 0; m_wait = 0; m_ret = 0; path.delete(); m_valid = 1;
    end else if (m_valid) begin
      is_mem = (m_state == 0 || m_state == 3 || m_state == 5);
      e_err  = is_mem && !bus.mem_ready && m_wait == 15;
      fin    = !is_mem || bus.mem_ready;
      rq.delete();
      if (m_state == 1) begin
        case (bus.opcode)
          6'b100011: rq = '{2, 3, 4};
          6'b101011: rq = '{2, 5};
          6'b000000: rq = '{6, 7};
          6'b000100: rq = '{8};
          6'b000010: rq = '{9};
`ifdef MC_MIPS_CTRL_ADDI_EN
          6'b001000: rq = '{10, 11};
`endif
          default: ;
        endcase
      end
      e_ill  = (m_state == 1) && rq.size() == 0;
      e_done = !e_err && fin && m_state > 1 && path.size() == 0;
      e_ctl  = e_err ? 16'h0 : spec_ctl(m_state, bus.mem_ready);

      chk("m_state", int'(state), m_state);
      chk("m_ctl", int'(dut_ctl), int'(e_ctl));
      chk("m_done", int'(instr_done), int'(e_done));
      chk("m_illegal", int'(illegal_op), int'(e_ill));
      chk("m_memerr", int'(mem_err), int'(e_err));
      chk("m_retired", int'(retired), m_ret);

      if (e_err) begin
        nxt = 0; path.delete();
      end else if (!fin) begin
        nxt = m_state;
      end else if (m_state == 0) begin
        nxt = 1;
      end else begin
        if (m_state == 1) path = rq;
        nxt = (path.size() != 0) ? path.pop_front() : 0;
      end
      if (e_done) m_ret++;
      m_wait = (!e_err && !fin) ? m_wait + 1 : 0;
      m_state = nxt;
    end
  end

  // Directed stimulus; one call = one clock cycle, outputs sampled mid-cycle.
  int s_state, s_ret, s_done, s_ill, s_err, s_mr, s_mw, s_rw, s_m2r, s_irw, s_pcw;
  int c_a, c_b, c_c;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  task automatic cyc(input bit r, input bit rdy, input logic [5:0] op);
    rst = r; bus.mem_ready = rdy; bus.opcode = op;
    @(negedge clk);
    s_state = int'(state); s_ret = int'(retired); s_done = int'(instr_done);
    s_ill = int'(illegal_op); s_err = int'(mem_err);
    s_mr = int'(bus.MemRead); s_mw = int'(bus.MemWrite); s_rw = int'(bus.RegWrite);
    s_m2r = int'(bus.MemtoReg); s_irw = int'(bus.IRWrite); s_pcw = int'(bus.PCWrite);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) cyc(0, 1, RT);

    // release reset: FETCH of a lw, zero-wait memory
    cyc(1, 1, LW);
    chk("rst_state0", s_state, 0);
    chk("rst_memread", s_mr, 1);
    chk("rst_retired", s_ret, 0);
    chk("fetch_irwrite", s_irw, 1);
    chk("fetch_pcwrite", s_pcw, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 1, LW);
      chk("lw_state", s_state, i);
    end
    chk("lw_regwrite", s_rw, 1);
    chk("lw_memtoreg", s_m2r, 1);
    chk("lw_done", s_done, 1);

    // sw with three wait cycles in MEMWR
    cyc(1, 1, SW);
    chk("lw_back_fetch", s_state, 0);
    chk("lw_retired", s_ret, 1);
    c_a = 0; c_b = 0; c_c = 0;
    cyc(1, 1, SW); c_b += s_done;
    cyc(1, 1, SW); c_b += s_done;
    chk("sw_memadr", s_state, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 3, SW);
      chk("sw_memwr_state", s_state, 5);
      c_a += s_mw; c_b += s_done; c_c += s_rw;
    end
    chk("sw_memwrite_cycles", c_a, 4);
    chk("sw_done_count", c_b, 1);
    chk("sw_regwrite_count", c_c, 0);

    // beq, R-type, j
    cyc(1, 1, BEQ); chk("beq_retired_in", s_ret, 2);
    cyc(1, 1, BEQ);
    cyc(1, 1, BEQ); chk("beq_state", s_state, 8); chk("beq_done", s_done, 1);
    cyc(1, 1, RT); cyc(1, 1, RT);
    cyc(1, 1, RT); chk("r_exec", s_state, 6);
    cyc(1, 1, RT); chk("r_aluwb", s_state, 7); chk("r_regwrite", s_rw, 1);
    cyc(1, 1, JMP); cyc(1, 1, JMP);
    cyc(1, 1, JMP); chk("j_state", s_state, 9); chk("j_pcwrite", s_pcw, 1);

    // mem_ready arriving exactly in the limit cycle completes normally
    c_a = 0;
    for (int i = 0; i < 15; i++) begin cyc(1, 0, JMP); c_a += s_err; end
    cyc(1, 1, JMP);
    chk("limit_retired", s_ret, 5);
    chk("limit_no_err", c_a + s_err, 0);
    chk("limit_irwrite", s_irw, 1);
    cyc(1, 1, JMP); chk("limit_decode", s_state, 1);
    cyc(1, 1, JMP);

    // FETCH timeout, then an illegal opcode
    c_a = 0; c_b = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, BAD); c_a += s_err; c_b += s_pcw;
    end
    chk("to_err_last", s_err, 1);
    chk("to_err_count", c_a, 1);
    chk("to_no_pcwrite", c_b, 0);
    cyc(1, 1, BAD); chk("to_state", s_state, 0);
    cyc(1, 1, BAD); chk("bad_illegal", s_ill, 1);
    cyc(1, 1, LW);  chk("bad_state", s_state, 0); chk("bad_retired", s_ret, 6);

    // MEMRD timeout abandons the lw without retiring
    cyc(1, 1, LW); cyc(1, 1, LW);
    c_a = 0;
    for (int i = 0; i < 16; i++) begin cyc(1, 0, LW); c_a += s_rw; end
    chk("rd_to_err", s_err, 1);
    chk("rd_to_no_regwrite", c_a, 0);

    // addi: optional feature
    cyc(1, 1, ADDI); chk("rd_to_state", s_state, 0); chk("rd_to_retired", s_ret, 6);
    cyc(1, 1, ADDI);
`ifdef MC_MIPS_CTRL_ADDI_EN
    chk("addi_illegal", s_ill, 0);
    cyc(1, 1, ADDI); chk("addi_ex", s_state, 10);
    cyc(1, 1, ADDI); chk("addi_wb", s_state, 11); chk("addi_regwrite", s_rw, 1);
    cyc(1, 1, LW); chk("addi_retired", s_ret, 7);
`else
    chk("addi_illegal", s_ill, 1);
    cyc(1, 1, LW); chk("addi_retired", s_ret, 6);
`endif

    // reset while stalled in MEMRD
    cyc(1, 1, LW); cyc(1, 1, LW);
    cyc(1, 0, LW); chk("mid_memrd", s_state, 3);
    cyc(0, 0, LW);
    chk("mid_regwrite", s_rw, 0);
    chk("mid_memread", s_mr, 0);
    chk("mid_done", s_done, 0);
    cyc(1, 1, LW);
    chk("mid_state", s_state, 0);
    chk("mid_retired", s_ret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_mips_ctrl.md
Name: mc_mips_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS core's next datapath revision: one shared memory, IR, ALUOut and PC register.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives the datapath mux selects and write enables.
- Stalls on a variable-latency memory handshake.
- Counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_WAIT_MAX, 15: max cycles a memory state waits for mem_ready before aborting with mem_err.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  standard multi-cycle control strobes/selects.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst=0 at edge): state<=FETCH(0), wait counter<=0, retired<=0. While rst=0, all control outputs, instr_done, illegal_op and mem_err are forced to 0. rst low mid-instruction abandons it; no write strobe is asserted in that cycle.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=1 only in the cycle mem_ready=1 (Mealy), then ->DECODE; otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - opcode 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX (see Optional Feature).
  - Any other opcode: illegal_op=1, ->FETCH, no retire.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1; mem_ready -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; retire; ->FETCH.
- MEMWR: MemWrite=1, IorD=1 held until mem_ready; then retire, ->FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; retire; ->FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; retire; ->FETCH.
- JUMP: PCWrite=1, PCSource=10; retire; ->FETCH.
- Unlisted outputs are 0 in every state.
- Retire: instr_done=1 in the retiring cycle; retired<=retired+1 at that edge; wraps modulo 2^CNT_W.
- Memory wait (FETCH, MEMRD, MEMWR):
  - Counter clears on state entry and increments each cycle mem_ready=0.
  - If it reaches MEMWAIT_MAX with mem_ready=0: mem_err=1, all strobes 0 that cycle, ->FETCH, PC unchanged.
  - mem_ready=1 in the same cycle as the limit wins: normal completion.
- mem_ready outside a memory state is ignored.
- Latency with zero-wait memory: R/beq 3+1, lw 5, sw 4, j 3 cycles.

Optional Feature:
- Macro MC_MIPS_CTRL_ADDI_EN.
- Defined: opcode 001000 -> ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00) -> ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0; retire) -> FETCH.
- Undefined: ADDIEX/ADDIWB states are not built, and 001000 is treated as illegal.

Decomposition:
- Shared package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALUOp codes, ALUSrcB/PCSource encodings, 4-bit state enum.
- One sub-module, mc_mem_wait_timer: wait counter plus timeout compare, parameterised by MEM_WAIT_MAX.

Test Plan:
- Reset: hold rst=0 3 cycles, then release with mem_ready=1 -> state=0, MemRead=1, retired=0; next edge IRWrite=PCWrite=1 pulse, state=1.
- lw with mem_ready tied 1: opcode=100011 -> states 0,1,2,3,4,0; RegWrite=MemtoReg=1 in state 4; retired=1.
- sw with 3 wait cycles: opcode=101011, mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, a single instr_done, no RegWrite.
- Timeout: mem_ready=0 forever in FETCH -> mem_err pulses after 15 cycles, state back to 0, PCWrite never 1.
- Illegal/addi: opcode=001000. With the macro undefined: illegal_op pulse, retired unchanged. With it defined: states 10, 11, RegWrite=1, retired+1.
- Mid-instruction reset: rst=0 while in MEMRD -> next state=0, no RegWrite, retired=0.
